// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Time-multiplexes one serial fully-connected layer datapath across
// NUM_LAYERS network layers. An input vector of SIZE elements is accepted
// over a valid/ready stream into a local buffer. Each layer pass then:
//   CLR   - pulses dp_rst for one cycle and presents the layer's weight bank
//   FEED  - streams the buffer out serially on dp_x / dp_feed
//   WAIT  - idles PIPE_LAT cycles while the datapath pipeline fills
//   DRAIN - captures SIZE serial results from y_in back into the buffer
// After the last layer the buffer is streamed out over a valid/ready stream.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start                begin an inference (only looked at while idle)
//   busy                 high in every state except idle
//   done                 one-cycle pulse on the last output handshake
//   in_valid/in_ready/in_data     input element stream
//   dp_rst               datapath clear, one cycle per layer
//   dp_x/dp_feed         serial operand to the datapath (dp_x is 0 unless fed)
//   layer_sel            weight-bank select, stable from CLR through DRAIN
//   y_in                 serial result from the datapath
//   out_valid/out_ready/out_data  output element stream
//
// All outputs except done come straight from flops. done must coincide with
// the final output handshake, so it is decoded from state and out_ready.
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int SIZE       = 3,
  parameter int BIT_SIZE   = 8,
  parameter int NUM_LAYERS = 4,
  parameter int PIPE_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_data,
  output logic                dp_rst,
  output logic [BIT_SIZE-1:0] dp_x,
  output logic                dp_feed,
  output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] layer_sel,
  input  logic [BIT_SIZE-1:0] y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_data
);

  // Counter widths. k must be able to hold SIZE, the buffer index only SIZE-1.
  localparam int K_W   = $clog2(SIZE + 1);
  localparam int IDX_W = $clog2(SIZE);
  localparam int L_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int W_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [K_W-1:0] K_LAST = K_W'(SIZE - 1);
  localparam logic [L_W-1:0] L_LAST = L_W'(NUM_LAYERS - 1);
  localparam logic [W_W-1:0] W_LAST = W_W'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLR   = 3'd2,
    S_FEED  = 3'd3,
    S_WAIT  = 3'd4,
    S_DRAIN = 3'd5,
    S_OUT   = 3'd6
  } state_t;

  // Sequencer state and counters
  state_t         state_r, state_s;
  logic [K_W-1:0] k_r, k_s;
  logic [L_W-1:0] l_r, l_s;
  logic [W_W-1:0] w_r, w_s;

  // Vector buffer; rewritten in place by every DRAIN
  logic [BIT_SIZE-1:0] buf_r [SIZE];
  logic                buf_we_s;
  logic [BIT_SIZE-1:0] buf_wd_s;
  logic [IDX_W-1:0]    wr_idx_s;
  logic [IDX_W-1:0]    rd_idx_s;
  logic [BIT_SIZE-1:0] rd_data_s;

  logic done_s;

  // Next values for the registered outputs
  logic                busy_s, in_ready_s, dp_rst_s, dp_feed_s, out_valid_s;
  logic [BIT_SIZE-1:0] dp_x_s, out_data_s;
  logic                busy_r, in_ready_r, dp_rst_r, dp_feed_r, out_valid_r;
  logic [BIT_SIZE-1:0] dp_x_r, out_data_r;

  assign wr_idx_s = k_r[IDX_W-1:0];

  // Next-state, counter and buffer-write decode
  always_comb begin
    state_s  = state_r;
    k_s      = k_r;
    l_s      = l_r;
    w_s      = w_r;
    buf_we_s = 1'b0;
    buf_wd_s = '0;
    done_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_LOAD;
          k_s     = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        // in_ready is high throughout LOAD, so in_valid alone is the handshake
        if (in_valid) begin
          buf_we_s = 1'b1;
          buf_wd_s = in_data;
          if (k_r == K_LAST) begin
            state_s = S_CLR;
            k_s     = '0;
            l_s     = '0;
          end else begin
            k_s = k_r + K_W'(1);
          end
        end else begin
          state_s = S_LOAD;
        end
      end
      S_CLR: begin
        state_s = S_FEED;
        k_s     = '0;
      end
      S_FEED: begin
        if (k_r == K_LAST) begin
          k_s     = '0;
          w_s     = '0;
          state_s = (PIPE_LAT == 0) ? S_DRAIN : S_WAIT;
        end else begin
          k_s = k_r + K_W'(1);
        end
      end
      S_WAIT: begin
        if (w_r == W_LAST) begin
          state_s = S_DRAIN;
          w_s     = '0;
        end else begin
          w_s = w_r + W_W'(1);
        end
      end
      S_DRAIN: begin
        // Overwriting the element just fed is safe: FEED finished first
        buf_we_s = 1'b1;
        buf_wd_s = y_in;
        if (k_r == K_LAST) begin
          k_s = '0;
          if (l_r == L_LAST) begin
            state_s = S_OUT;
          end else begin
            l_s     = l_r + L_W'(1);
            state_s = S_CLR;
          end
        end else begin
          k_s = k_r + K_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (k_r == K_LAST) begin
            done_s  = 1'b1;
            state_s = S_IDLE;
            k_s     = '0;
            l_s     = '0;
          end else begin
            k_s = k_r + K_W'(1);
          end
        end else begin
          state_s = S_OUT;
        end
      end
      default: begin
        state_s = S_IDLE;
        k_s     = '0;
        l_s     = '0;
        w_s     = '0;
      end
    endcase
  end

  // Output decode from the next state, so the flopped outputs line up with it
  always_comb begin
    rd_idx_s = k_s[IDX_W-1:0];
    // Forward a same-cycle buffer write so the next read sees fresh data
    if (buf_we_s && (rd_idx_s == wr_idx_s)) begin
      rd_data_s = buf_wd_s;
    end else begin
      rd_data_s = buf_r[rd_idx_s];
    end
    busy_s      = (state_s != S_IDLE);
    in_ready_s  = (state_s == S_LOAD);
    dp_rst_s    = (state_s == S_CLR);
    dp_feed_s   = (state_s == S_FEED);
    out_valid_s = (state_s == S_OUT);
    if (state_s == S_FEED) begin
      dp_x_s = rd_data_s;
    end else begin
      dp_x_s = '0;
    end
    if (state_s == S_OUT) begin
      out_data_s = rd_data_s;
    end else begin
      out_data_s = '0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      k_r     <= '0;
      l_r     <= '0;
      w_r     <= '0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      l_r     <= l_s;
      w_r     <= w_s;
    end
  end

  // Vector buffer storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        buf_r[i] <= '0;
      end
    end else if (buf_we_s) begin
      buf_r[wr_idx_s] <= buf_wd_s;
    end else begin
      buf_r <= buf_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      dp_rst_r    <= 1'b0;
      dp_feed_r   <= 1'b0;
      out_valid_r <= 1'b0;
      dp_x_r      <= '0;
      out_data_r  <= '0;
    end else begin
      busy_r      <= busy_s;
      in_ready_r  <= in_ready_s;
      dp_rst_r    <= dp_rst_s;
      dp_feed_r   <= dp_feed_s;
      out_valid_r <= out_valid_s;
      dp_x_r      <= dp_x_s;
      out_data_r  <= out_data_s;
    end
  end

  assign busy      = busy_r;
  assign in_ready  = in_ready_r;
  assign dp_rst    = dp_rst_r;
  assign dp_feed   = dp_feed_r;
  assign dp_x      = dp_x_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign layer_sel = l_r;
  assign done      = done_s;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//
// Two sequencers: A (SIZE=3, NUM_LAYERS=4, PIPE_LAT=1) driving a datapath
// model y=x+1, and B (SIZE=3, NUM_LAYERS=1, PIPE_LAT=0) with identity y=x.
// Table rows and random vectors are run through A; the expected output of an
// inference is simply each input element plus NUM_LAYERS*increment.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

  localparam int SIZE = 3;
  localparam int NL_A = 4;
  localparam int PL_A = 1;
  localparam int NL_B = 1;
  localparam int PL_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A signals
  logic       rst_a, start_a, busy_a, done_a, in_valid_a, in_ready_a;
  logic [7:0] in_data_a, dp_x_a, y_in_a, out_data_a;
  logic       dp_rst_a, dp_feed_a, out_valid_a, out_ready_a;
  logic [1:0] layer_sel_a;

  // Instance B signals
  logic       rst_b, start_b, busy_b, done_b, in_valid_b, in_ready_b;
  logic [7:0] in_data_b, dp_x_b, y_in_b, out_data_b;
  logic       dp_rst_b, dp_feed_b, out_valid_b, out_ready_b;
  logic [0:0] layer_sel_b;

  layer_sequencer #(.SIZE(SIZE), .BIT_SIZE(8), .NUM_LAYERS(NL_A), .PIPE_LAT(PL_A)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .dp_rst(dp_rst_a), .dp_x(dp_x_a), .dp_feed(dp_feed_a), .layer_sel(layer_sel_a),
    .y_in(y_in_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a)
  );

  layer_sequencer #(.SIZE(SIZE), .BIT_SIZE(8), .NUM_LAYERS(NL_B), .PIPE_LAT(PL_B)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .dp_rst(dp_rst_b), .dp_x(dp_x_b), .dp_feed(dp_feed_b), .layer_sel(layer_sel_b),
    .y_in(y_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b)
  );

  // Datapath model A: collects fed x values, presents x+1 PIPE_LAT+1 cycles
  // after the last feed, one element per cycle.
  logic [7:0] fx_a [SIZE];
  int fc_a = 0, rc_a = 0, dly_a = -1;
  always @(posedge clk) begin
    if (dp_rst_a) begin
      fc_a <= 0; rc_a <= 0; dly_a <= -1;
    end else if (dp_feed_a) begin
      if (fc_a < SIZE) fx_a[fc_a] <= dp_x_a;
      fc_a <= fc_a + 1;
      if (fc_a == SIZE - 1) begin dly_a <= PL_A; rc_a <= 0; end
    end else if (dly_a > 0) begin
      dly_a <= dly_a - 1;
    end else if (dly_a == 0) begin
      rc_a <= rc_a + 1;
    end
  end
  assign y_in_a = (dly_a == 0 && rc_a < SIZE) ? fx_a[rc_a] + 8'd1 : 8'd0;

  // Datapath model B: identity, first result the cycle after the last feed
  logic [7:0] fx_b [SIZE];
  int fc_b = 0, rc_b = 0, dly_b = -1;
  always @(posedge clk) begin
    if (dp_rst_b) begin
      fc_b <= 0; rc_b <= 0; dly_b <= -1;
    end else if (dp_feed_b) begin
      if (fc_b < SIZE) fx_b[fc_b] <= dp_x_b;
      fc_b <= fc_b + 1;
      if (fc_b == SIZE - 1) begin dly_b <= PL_B; rc_b <= 0; end
    end else if (dly_b > 0) begin
      dly_b <= dly_b - 1;
    end else if (dly_b == 0) begin
      rc_b <= rc_b + 1;
    end
  end
  assign y_in_b = (dly_b == 0 && rc_b < SIZE) ? fx_b[rc_b] : 8'd0;

  // Per-cycle trace of datapath-side outputs for timing checks
  typedef struct packed {
    logic       rst;
    logic       feed;
    logic       ov;
    logic [1:0] sel;
    logic [7:0] x;
  } lg_t;
  lg_t lg [256];
  int  lg_n = 0;
  logic log_en = 1'b0;
  logic log_src = 1'b0;
  always @(negedge clk) begin
    if (!log_en) begin
      lg_n <= 0;
    end else if (lg_n < 256) begin
      if (!log_src) lg[lg_n] <= {dp_rst_a, dp_feed_a, out_valid_a, layer_sel_a, dp_x_a};
      else          lg[lg_n] <= {dp_rst_b, dp_feed_b, out_valid_b, 1'b0, layer_sel_b, dp_x_b};
      lg_n <= lg_n + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: each element passes through nl layers adding inc per layer
  function automatic logic [23:0] ref_out(input logic [23:0] v, input int nl, input int inc);
    logic [23:0] r;
    for (int i = 0; i < SIZE; i++) r[8*i +: 8] = v[8*i +: 8] + 8'(nl * inc);
    return r;
  endfunction

  // Check trace timing against the pass structure 1 + SIZE + PIPE_LAT + SIZE
  task automatic analyse(input int nl, input int plat, input logic [23:0] vin);
    int c0, co, nrst, nfeed, selbad, posbad, xbad, pass, c;
    c0 = -1; co = -1; nrst = 0; nfeed = 0; selbad = 0; posbad = 0; xbad = 0;
    pass = 1 + 2 * SIZE + plat;
    for (int i = 0; i < lg_n; i++) begin
      if (lg[i].rst) begin if (c0 < 0) c0 = i; nrst++; end
      if (lg[i].ov && co < 0) co = i;
      if (lg[i].feed) nfeed++;
      else if (lg[i].x != 8'd0) xbad++;
    end
    chk("clr_to_out_cycles", co - c0, nl * pass);
    chk("dp_rst_count", nrst, nl);
    chk("dp_feed_count", nfeed, nl * SIZE);
    chk("dp_x_zero_when_idle", xbad, 0);
    if (c0 >= 0) begin
      for (int j = 0; j < nl; j++) begin
        for (int o = 0; o < pass; o++) begin
          c = c0 + j * pass + o;
          if (c < lg_n) begin
            if (lg[c].feed != (o >= 1 && o <= SIZE)) posbad++;
            if (lg[c].rst != (o == 0)) posbad++;
            if (int'(lg[c].sel) != j) selbad++;
          end else begin
            posbad++;
          end
        end
      end
      for (int i = 0; i < SIZE; i++)
        chk("dp_x_layer0", int'(lg[c0 + 1 + i].x), int'(vin[8*i +: 8]));
    end
    chk("layer_sel_steps", selbad, 0);
    chk("pulse_positions", posbad, 0);
  endtask

  // One inference on A. Called at a negedge; start is raised immediately.
  // in_mode: 0 always valid, 1 toggle 1,0,1,0,1 then stray valids, 2 random.
  // out_mode: 0 always ready, 1 five-cycle stall after first word, 2 random.
  task automatic run_a(input logic [23:0] vin, input logic [23:0] vexp,
                       input int in_mode, input int out_mode, input bit spur);
    logic vld, rdy;
    int i, cyc, oi, stall, t0, dcnt, dlast;
    bit fired;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    i = 0; cyc = 0;
    while (i < SIZE && cyc < 200) begin
      case (in_mode)
        1: vld = (cyc % 2 == 0);
        2: vld = 1'($urandom_range(0, 1));
        default: vld = 1'b1;
      endcase
      in_valid_a = vld;
      in_data_a  = vld ? vin[8*i +: 8] : 8'hEE;
      if (vld && in_ready_a) i++;
      cyc++;
      @(negedge clk);
    end
    if (i < SIZE) chk("load_timeout", i, SIZE);
    oi = 0; cyc = 0; stall = 0; t0 = -1; dcnt = 0; dlast = -1; fired = 1'b0;
    while (oi < SIZE && cyc < 400) begin
      in_valid_a = (in_mode == 1 && cyc < 2);
      in_data_a  = 8'hEE;
      start_a    = spur && !fired && dp_feed_a && (layer_sel_a == 2'd2);
      if (start_a) fired = 1'b1;
      case (out_mode)
        1: rdy = (stall == 0);
        2: rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      out_ready_a = rdy;
      #1;
      if (done_a) begin dcnt++; dlast = cyc - t0; end
      if (out_valid_a) begin
        if (t0 < 0) t0 = cyc;
        if (rdy) begin
          chk("out_word", int'(out_data_a), int'(vexp[8*oi +: 8]));
          oi++;
          if (out_mode == 1 && oi == 1) stall = 5;
        end else if (stall > 0) begin
          chk("out_hold", int'(out_data_a), int'(vexp[8*oi +: 8]));
          stall--;
        end
      end
      cyc++;
      @(negedge clk);
    end
    start_a = 1'b0; out_ready_a = 1'b1; in_valid_a = 1'b0;
    if (oi < SIZE) chk("out_timeout", oi, SIZE);
    chk("done_count", dcnt, 1);
    if (out_mode == 0) chk("done_latency", dlast, SIZE - 1);
    if (out_mode == 1) chk("done_latency_stall", dlast, SIZE - 1 + 5);
    if (spur) chk("spurious_start_issued", int'(fired), 1);
    chk("idle_after_done_busy", int'(busy_a), 0);
    chk("idle_after_done_valid", int'(out_valid_a), 0);
  endtask

  typedef struct {
    logic [23:0] vin;
    logic [23:0] vexp;
    int in_mode;
    int out_mode;
    bit spur;
    bit timing;
  } vec_t;

  vec_t tbl [5];
  logic [23:0] rv;
  int cyc, oi;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Element 0 sits in the low byte
    tbl[0] = '{vin: {8'd7, 8'd6, 8'd5},     vexp: {8'd11, 8'd10, 8'd9},  in_mode: 0, out_mode: 0, spur: 0, timing: 1};
    tbl[1] = '{vin: {8'd0, 8'd0, 8'd0},     vexp: {8'd4, 8'd4, 8'd4},    in_mode: 1, out_mode: 0, spur: 0, timing: 0};
    tbl[2] = '{vin: {8'd253, 8'd254, 8'd255}, vexp: {8'd1, 8'd2, 8'd3},  in_mode: 0, out_mode: 1, spur: 0, timing: 0};
    tbl[3] = '{vin: {8'd1, 8'd100, 8'd252}, vexp: {8'd5, 8'd104, 8'd0},  in_mode: 2, out_mode: 2, spur: 0, timing: 0};
    tbl[4] = '{vin: {8'd7, 8'd6, 8'd5},     vexp: {8'd11, 8'd10, 8'd9},  in_mode: 0, out_mode: 0, spur: 1, timing: 1};

    rst_a = 1'b1; start_a = 1'b0; in_valid_a = 1'b0; in_data_a = 8'd0; out_ready_a = 1'b1;
    rst_b = 1'b1; start_b = 1'b0; in_valid_b = 1'b0; in_data_b = 8'd0; out_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_in_ready", int'(in_ready_a), 0);
    chk("rst_dp_rst", int'(dp_rst_a), 0);
    chk("rst_dp_feed", int'(dp_feed_a), 0);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_dp_x", int'(dp_x_a), 0);
    chk("rst_out_data", int'(out_data_a), 0);
    chk("rst_layer_sel", int'(layer_sel_a), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready_a), 0);

    // Table-driven inferences on A
    for (int t = 0; t < 5; t++) begin
      log_src = 1'b0;
      log_en  = tbl[t].timing;
      run_a(tbl[t].vin, tbl[t].vexp, tbl[t].in_mode, tbl[t].out_mode, tbl[t].spur);
      if (tbl[t].timing) analyse(NL_A, PL_A, tbl[t].vin);
      log_en = 1'b0;
      @(negedge clk);
    end

    // Back-to-back: start raised in IDLE one cycle after done
    run_a({8'd7, 8'd6, 8'd5}, {8'd11, 8'd10, 8'd9}, 0, 0, 0);
    run_a({8'd30, 8'd20, 8'd10}, {8'd34, 8'd24, 8'd14}, 0, 0, 0);
    @(negedge clk);

    // Mid-run reset during DRAIN of layer 1
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      in_valid_a = 1'b1; in_data_a = 8'(5 + i); @(negedge clk);
    end
    in_valid_a = 1'b0;
    cyc = 0;
    while (!(dp_feed_a && layer_sel_a == 2'd1) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    chk("reach_layer1_feed", int'(dp_feed_a && layer_sel_a == 2'd1), 1);
    repeat (SIZE + PL_A) @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_out_valid", int'(out_valid_a), 0);
    chk("midrst_in_ready", int'(in_ready_a), 0);
    chk("midrst_done", int'(done_a), 0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("postrst_busy", int'(busy_a), 0);
    chk("postrst_layer_sel", int'(layer_sel_a), 0);
    run_a({8'd7, 8'd6, 8'd5}, {8'd11, 8'd10, 8'd9}, 0, 0, 0);
    @(negedge clk);

    // Randomized inferences on A against the reference model
    for (int r = 0; r < 20; r++) begin
      rv = 24'($urandom);
      run_a(rv, ref_out(rv, NL_A, 1), 2, 2, 0);
    end
    @(negedge clk);

    // Instance B: PIPE_LAT=0, single layer, identity datapath
    log_src = 1'b1; log_en = 1'b1;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      in_valid_b = 1'b1; in_data_b = 8'(1 + i); @(negedge clk);
    end
    in_valid_b = 1'b0;
    oi = 0; cyc = 0;
    while (oi < SIZE && cyc < 100) begin
      if (out_valid_b) begin
        chk("b_out_word", int'(out_data_b), oi + 1);
        if (oi == SIZE - 1) chk("b_done", int'(done_b), 1);
        oi++;
      end
      cyc++;
      @(negedge clk);
    end
    if (oi < SIZE) chk("b_out_timeout", oi, SIZE);
    analyse(NL_B, PL_B, {8'd3, 8'd2, 8'd1});
    chk("b_idle_busy", int'(busy_b), 0);
    log_en = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controller that time-multiplexes one serial fully-connected layer datapath (SIZE neurons, BIT_SIZE-bit serial x/y) across NUM_LAYERS network layers.
- Accepts an input vector over a valid/ready stream and buffers it locally.
- For each layer: selects that layer's weight set, clears the datapath, feeds the vector serially, then captures the serial result back into the buffer.
- After the last layer, emits the final vector over a valid/ready output stream.
- Sits between the host/DMA streams and the layer datapath plus its weight-bank mux.

Parameters:
SIZE, 3, vector length = neurons per layer (≥2)
BIT_SIZE, 8, width of one vector element
NUM_LAYERS, 4, number of layer passes per inference (≥1)
PIPE_LAT, 1, cycles from last feed cycle to first valid y_in (0..7)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin inference; sampled in IDLE only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last output word handshakes
in_valid  in  1  input element valid
in_ready  out  1  high only in LOAD
in_data  in  BIT_SIZE  input element
dp_rst  out  1  datapath clear; high for exactly one cycle per layer (CLR)
dp_x  out  BIT_SIZE  serial x to datapath
dp_feed  out  1  dp_x valid this cycle
layer_sel  out  clog2(NUM_LAYERS) (min 1)  weight-bank select for current layer
y_in  in  BIT_SIZE  serial y from datapath
out_valid  out  1  output element valid
out_ready  in  1  downstream accepts
out_data  out  BIT_SIZE  output element

Behaviour:
- Reset (async): state=IDLE, all counters=0, layer_sel=0, buffer cleared to 0. Outputs busy, done, in_ready, dp_rst, dp_feed, out_valid = 0; dp_x=0, out_data=0.
- Storage: buf[0..SIZE-1] of BIT_SIZE; element counter k (clog2(SIZE+1) bits); layer counter L; wait counter.
- IDLE: start=1 -> LOAD, k=0. A start pulse in any other state is ignored.
- LOAD: in_ready=1. On in_valid&in_ready, buf[k]<=in_data and k++. After the SIZE-th handshake -> CLR with L=0. No timeout.
- CLR: dp_rst=1 for 1 cycle; layer_sel=L, held stable from CLR through end of DRAIN. Next state -> FEED, k=0.
- FEED: SIZE cycles, dp_feed=1, dp_x=buf[k], k++. After k=SIZE-1: if PIPE_LAT=0 -> DRAIN, else -> WAIT. k=0 on exit.
- WAIT: PIPE_LAT cycles, dp_feed=0, then -> DRAIN.
- DRAIN: SIZE cycles, buf[k]<=y_in, k++. After the last capture:
  - if L==NUM_LAYERS-1 -> OUT, k=0;
  - else L++ -> CLR.
- dp_x is 0 whenever dp_feed=0.
- In-place overwrite of buf is legal because FEED completes before DRAIN starts.
- Pass length per layer: 1 + SIZE + PIPE_LAT + SIZE cycles.
- OUT: out_valid=1, out_data=buf[k] (registered, stable while out_valid & !out_ready). On handshake k++. On the SIZE-th handshake: done=1 in the same cycle, next state -> IDLE, out_valid deasserts the following cycle.
- Backpressure: out_ready low holds the state indefinitely. No other state waits on any external signal.
- Values pass through unmodified; no arithmetic on data; no saturation.
- Async rst mid-operation (any state): immediate return to reset values. Partial buffer contents are discarded, with no done pulse.

Test Plan:
- Basic inference: SIZE=3, NUM_LAYERS=4, PIPE_LAT=1; datapath model y=x+1 (one cycle late). Load 5,6,7 -> outputs 9,10,11 in order, done pulses once. Exactly 32 cycles from CLR entry to OUT entry.
- Per-layer sequencing: check dp_rst pulses exactly 4 times and layer_sel steps 0,1,2,3, each value constant for 8 cycles. dp_feed high 3 cycles per layer; dp_x sequence for layer 0 = 5,6,7.
- Handshake stalls: in_valid toggled 1,0,1,0,1 -> only 3 elements captured, with no extra capture. Hold out_ready=0 for 5 cycles mid-output -> out_data stays constant, done delayed accordingly.
- PIPE_LAT=0, NUM_LAYERS=1, identity model (y=x, same cycle after last feed) -> load 1,2,3, output 1,2,3. No WAIT cycles; pass length is 7 cycles.
- Spurious start: pulse start during FEED of layer 2 -> no effect on sequence or output values. Start in IDLE one cycle after done -> new LOAD accepted.
- Mid-run reset: assert rst during DRAIN of layer 1 -> same cycle busy=0, out_valid=0, in_ready=0. After release: IDLE, layer_sel=0, and a fresh inference 5,6,7 yields 9,10,11.
